// File: rtl/mix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mix_pkg
// Description : Shared MIX constants, the CHAR converter state encoding and
//               the BCD-digit to MIX character-code helper.
// Contents    : MIX_BYTE_BITS, MIX_WORD_BITS, MIX_CHAR_ZERO, MIX_DIGITS,
//               conv_state_e, bcd_to_char()
// Revision    : 1.0 - initial release
// ============================================================================
package mix_pkg;

  localparam int          MIX_BYTE_BITS = 6;
  localparam int          MIX_WORD_BITS = 30;
  localparam int          MIX_DIGITS    = 10;
  localparam logic [5:0]  MIX_CHAR_ZERO = 6'd30;

  // Converter control states. DONE is the single cycle in which stop is high.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  // MIX character code of a decimal digit: '0' is code 30, '9' is code 39.
  function automatic logic [5:0] bcd_to_char(input logic [3:0] digit);
    return MIX_CHAR_ZERO + {2'b00, digit};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mix_char_if.sv
`default_nettype none
// ============================================================================
// Module      : mix_char_if
// Description : Start/stop handshake between the execute sequencer (master)
//               and the CHAR conversion unit (slave).
// Signals     : start - one-cycle request, in sampled on the same edge
//               in    - unsigned magnitude of rA
//               stop  - one-cycle completion pulse
//               out   - ten character codes, [59:30] -> rA, [29:0] -> rX
// Revision    : 1.0 - initial release
// ============================================================================
interface mix_char_if
  import mix_pkg::*;
#(
  parameter int WORD_BITS = MIX_WORD_BITS,
  parameter int DIGITS    = MIX_DIGITS
) ();

  logic                              start;
  logic [WORD_BITS-1:0]              in;
  logic                              stop;
  logic [DIGITS*MIX_BYTE_BITS-1:0]   out;

  modport master (output start, output in, input  stop, input  out);
  modport slave  (input  start, input  in, output stop, output out);

endinterface
`default_nettype wire

// File: rtl/mix_bcd_adj3.sv
`default_nettype none
// ============================================================================
// Module      : mix_bcd_adj3
// Description : Double-dabble correction cell for one BCD digit. A digit of
//               5 or more gets +3 so the following left shift carries into
//               the next digit exactly when the doubled value reaches 10.
// Ports       : in  - 4-bit BCD digit before the shift
//               out - corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
module mix_bcd_adj3
  import mix_pkg::*;
(
  input  logic [3:0] in,
  output logic [3:0] out
);

  assign out = (in >= 4'd5) ? (in + 4'd3) : in;

endmodule
`default_nettype wire

// File: rtl/mix_char.sv
`default_nettype none
// ============================================================================
// Module      : mix_char
// Description : MIX CHAR instruction datapath. Converts the 30-bit magnitude
//               of rA into ten decimal digits in MIX character code using an
//               iterative double-dabble, one bit per cycle. Result is ready
//               31 cycles after start, flagged by a one-cycle stop pulse.
// Ports       : clk   - clock
//               reset - synchronous active-high reset
//               bus   - mix_char_if slave (start/in request, stop/out result)
// Revision    : 1.0 - initial release
// ============================================================================
module mix_char
  import mix_pkg::*;
#(
  parameter int WORD_BITS = MIX_WORD_BITS,
  parameter int DIGITS    = MIX_DIGITS
) (
  input  logic       clk,
  input  logic       reset,
  mix_char_if.slave  bus
);

  localparam int         BCD_BITS  = 4 * DIGITS;
  localparam int         OUT_BITS  = DIGITS * MIX_BYTE_BITS;
  localparam logic [4:0] LAST_ITER = 5'(WORD_BITS - 1);

  conv_state_e          state_q, state_d;
  logic [WORD_BITS-1:0] bin_q,   bin_d;
  logic [BCD_BITS-1:0]  bcd_q,   bcd_d;
  logic [4:0]           cnt_q,   cnt_d;
  logic                 stop_q,  stop_d;
  logic [OUT_BITS-1:0]  out_q,   out_d;

  logic [BCD_BITS-1:0]  bcd_adj;
  logic [BCD_BITS-1:0]  bcd_shift;
  logic [WORD_BITS-1:0] bin_shift;
  logic [OUT_BITS-1:0]  codes;

  // One double-dabble step: correct every digit, then shift BCD:bin left
  // with the binary MSB entering the BCD LSB.
  assign bcd_shift = {bcd_adj[BCD_BITS-2:0], bin_q[WORD_BITS-1]};
  assign bin_shift = {bin_q[WORD_BITS-2:0], 1'b0};

  // Codes are taken from the post-shift value so the final iteration's
  // result can be registered into out on the same edge that raises stop.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      mix_bcd_adj3 u_adj3 (
        .in  (bcd_q[4*i +: 4]),
        .out (bcd_adj[4*i +: 4])
      );
      assign codes[MIX_BYTE_BITS*i +: MIX_BYTE_BITS] = bcd_to_char(bcd_shift[4*i +: 4]);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    stop_d  = 1'b0;
    out_d   = out_q;
    case (state_q)
      // DONE behaves as idle so a start in the stop cycle is accepted.
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          bin_d   = bus.in;
          bcd_d   = '0;
          cnt_d   = 5'd0;
          state_d = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONV: begin
        bin_d = bin_shift;
        bcd_d = bcd_shift;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_DONE;
          stop_d  = 1'b1;
          out_d   = codes;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= 5'd0;
      stop_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      out_q   <= out_d;
    end
  end

  assign bus.stop = stop_q;
  assign bus.out  = out_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_char.sv
`default_nettype none
// ============================================================================
// Module      : tb_mix_char
// Description : Self-checking bench for mix_char. Expected codes come from a
//               decimal reference model and are queued when each start is
//               driven; they are popped and compared at the stop pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mix_char;
  import mix_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mix_char_if #(.WORD_BITS(30), .DIGITS(10)) bus ();

  mix_char #(.WORD_BITS(30), .DIGITS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  int stop_cnt    = 0;
  logic [59:0] sb_q[$];

  // Count stop pulses just after each active edge, away from the negedge
  // sampling used by the directed sequence.
  always @(posedge clk) begin
    #1;
    if (bus.stop === 1'b1) stop_cnt++;
  end

  function automatic logic [59:0] ref_codes(input logic [29:0] v);
    logic [59:0] r;
    int unsigned x;
    x = v;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      r[6*i +: 6] = 6'(30 + (x % 10));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge (cycle T+1).
  task automatic pulse_start(input logic [29:0] v, input bit push);
    bus.start = 1'b1;
    bus.in    = v;
    if (push) sb_q.push_back(ref_codes(v));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // lat is the number of cycles already elapsed since the start cycle.
  task automatic wait_stop(input string tag, input int lat0);
    int lat;
    logic [59:0] exp;
    lat = lat0;
    while (bus.stop !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd31);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 60'hx;
    check({tag, "_out"}, {4'h0, bus.out}, {4'h0, exp});
  endtask

  logic [59:0] first_res;
  int          base_cnt;

  initial begin
    reset    = 1'b1;
    bus.start = 1'b0;
    bus.in    = '0;
    repeat (3) @(negedge clk);
    check("reset_stop", 64'(bus.stop), 64'd0);
    check("reset_out", {4'h0, bus.out}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Zero input: all codes 30, exactly one stop pulse.
    base_cnt = stop_cnt;
    pulse_start(30'd0, 1'b1);
    wait_stop("zero", 1);
    @(negedge clk);
    check("zero_stop_width", 64'(bus.stop), 64'd0);
    repeat (3) @(negedge clk);
    check("zero_stop_count", 64'(stop_cnt - base_cnt), 64'd1);

    // 12345, explicit rA/rX halves as well.
    pulse_start(30'd12345, 1'b1);
    wait_stop("d12345", 1);
    check("d12345_rA", 64'(bus.out[59:30]), 64'({6'd30, 6'd30, 6'd30, 6'd30, 6'd30}));
    check("d12345_rX", 64'(bus.out[29:0]),  64'({6'd31, 6'd32, 6'd33, 6'd34, 6'd35}));
    @(negedge clk);

    // Maximum input.
    pulse_start(30'd1073741823, 1'b1);
    wait_stop("max", 1);
    check("max_codes", {4'h0, bus.out},
          {4'h0, 6'd31, 6'd30, 6'd37, 6'd33, 6'd37, 6'd34, 6'd31, 6'd38, 6'd32, 6'd33});
    @(negedge clk);

    // 999999999 with a stray start during busy.
    base_cnt = stop_cnt;
    pulse_start(30'd999999999, 1'b1);
    repeat (8) @(negedge clk);
    bus.start = 1'b1;
    bus.in    = 30'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_stop("nines", 10);
    repeat (40) @(negedge clk);
    check("nines_stop_count", 64'(stop_cnt - base_cnt), 64'd1);
    check("nines_hold", {4'h0, bus.out}, {4'h0, ref_codes(30'd999999999)});

    // Reset at T+10 aborts the conversion.
    base_cnt = stop_cnt;
    pulse_start(30'd123456, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_stop", 64'(stop_cnt - base_cnt), 64'd0);
    check("abort_out", {4'h0, bus.out}, 64'd0);

    pulse_start(30'd7, 1'b1);
    wait_stop("seven", 1);
    @(negedge clk);

    // Back-to-back: second start in the stop cycle of the first.
    pulse_start(30'd1000000, 1'b1);
    wait_stop("b2b_first", 1);
    first_res = bus.out;
    pulse_start(30'd42, 1'b1);
    check("b2b_stop_drop", 64'(bus.stop), 64'd0);
    repeat (15) @(negedge clk);
    check("b2b_hold", {4'h0, bus.out}, {4'h0, first_res});
    wait_stop("b2b_second", 16);
    check("b2b_last_two", 64'(bus.out[11:0]), 64'({6'd34, 6'd32}));
    check("b2b_queue_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
